relu_bwd_seq: RTL and testbench
===============================

// Module: relu_bwd_seq
// PURPOSE
//  ReLU backward (gradient) stage, the reverse-direction partner of the forward ReLU.
//  - Forward-pass tap: records one mask bit per activation in a mask FIFO.
//  - Backward pass: gates each incoming gradient with the oldest stored mask bit.
//  - Sits beside the forward ReLU, between the loss/back-prop datapath and the preceding layer's gradient input.
//  - Data: 2's complement; output keeps the input format.
// PARAMETERS
//  DATA_WIDTH  16  width of forward data and gradient data
//  MASK_DEPTH  64  mask FIFO entries, >=2; need not be a power of two
//  LEAK_SHIFT  3   arithmetic right shift for the negative-region gradient (RELU_BWD_LEAKY_EN only)
// PORTS
//  clk              in   1                     clock, rising edge
//  rst_n            in   1                     asynchronous active-low reset
//  i_en             in   1                     block enable
//  i_clr            in   1                     synchronous flush of FIFO and error flags
//  i_fwd_valid      in   1                     forward activation valid
//  i_fwd_data_bus   in   DATA_WIDTH            forward activation (pre-ReLU), signed
//  i_grad_valid     in   1                     gradient valid
//  i_grad_data_bus  in   DATA_WIDTH            upstream gradient, signed
//  o_valid          out  1                     output gradient valid
//  o_data_bus       out  DATA_WIDTH            masked gradient, signed
//  o_mask_count     out  $clog2(MASK_DEPTH+1)  stored mask entries
//  o_mask_full      out  1                     o_mask_count == MASK_DEPTH
//  o_mask_empty     out  1                     o_mask_count == 0
//  o_err_overflow   out  1                     sticky: forward push dropped
//  o_err_underflow  out  1                     sticky: gradient arrived with no mask
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - pointers, count, o_valid, o_err_* are 0; o_data_bus is all zeros; o_mask_empty=1; o_mask_full=0.
//  i_clr=1 (sampled at clk edge, overrides everything except reset):
//  - pointers, count, errors and o_valid clear; o_data_bus=0.
//  - Pushes and pops in the same cycle are ignored.
//  i_en=0: no push, no pop; next cycle o_valid=0, o_data_bus=0; FIFO contents retained.
//  Push (i_en & i_fwd_valid):
//  - writes mask = ~i_fwd_data_bus[DATA_WIDTH-1] (1 when input >= 0).
//  - This matches the forward rule: sign bit set -> zero.
//  Pop (i_en & i_grad_valid & ~o_mask_empty): reads the oldest mask bit m.
//  - next cycle o_valid=1 and o_data_bus = m ? i_grad_data_bus : 0.
//  - Latency is exactly 1 cycle.
//  - A cycle with no pop gives o_valid=0 and o_data_bus=0 next cycle; this is the dummy value.
//  Underflow (i_en & i_grad_valid & o_mask_empty):
//  - no output (o_valid=0 next cycle); o_err_underflow <= 1.
//  - There is no same-cycle push-to-pop bypass: a push into an empty FIFO becomes visible to pops one cycle later.
//  Overflow (push while full, no pop that cycle):
//  - mask is dropped, contents unchanged; o_err_overflow <= 1.
//  Push and pop in the same cycle while full: both proceed; count unchanged; no error.
//  Push and pop in the same cycle while 0 < count < MASK_DEPTH: count unchanged.
//  Pointers wrap from MASK_DEPTH-1 to 0. Count, full and empty are registered and consistent every cycle.
//  Error flags stay set until i_clr or reset.
//  Reset mid-stream: all state is lost immediately; the next cycle behaves as after power-on.
// CONFIGURATION
//  RELU_BWD_LEAKY_EN defined:
//  - for m=0, o_data_bus = i_grad_data_bus >>> LEAK_SHIFT (arithmetic, sign-preserving, truncating toward -inf).
//  - All other behaviour is unchanged.
//  RELU_BWD_LEAKY_EN undefined: m=0 gives 0. LEAK_SHIFT is unused.
// TESTING  (DATA_WIDTH=16, MASK_DEPTH=4)
//  - Reset: hold rst_n=0 -> o_valid=0, o_data_bus=16'h0000, o_mask_empty=1, o_mask_count=0, errors 0.
//  - Basic:
//    - push fwd 16'h0005, 16'hFFFB, 16'h0000.
//    - then grads 16'h0010, 16'h0020, 16'h0030 on consecutive cycles.
//    - expect outputs 16'h0010, 16'h0000, 16'h0030, each 1 cycle after its grad; then empty=1.
//  - Full/overflow:
//    - push 5 positive fwd values -> full=1 after the 4th; 5th dropped; o_err_overflow=1.
//    - 4 grads of 16'h0001 -> four outputs of 16'h0001; empty=1.
//  - Simultaneous at full: with count=4, push and grad in the same cycle -> output valid, count stays 4, no overflow.
//  - Underflow: grad 16'h0007 with empty FIFO -> o_valid=0 next cycle; o_err_underflow=1; i_clr pulse -> flag 0.
//  - Wrap plus leaky build:
//    - interleave 10 push/pop pairs across the pointer wrap; outputs must match a reference mask queue.
//    - with RELU_BWD_LEAKY_EN and LEAK_SHIFT=3: mask 0 and grad 16'hFFF0 -> output 16'hFFFE.

Source files
------------

// File: rtl/relu_bwd_seq.sv
// relu_bwd_seq -- ReLU backward (gradient) stage.
//
// Purpose:
//   During the forward pass each activation pushes one mask bit into a FIFO.
//   The bit is 1 when the activation is >= 0 and 0 when its sign bit is set.
//   During the backward pass each incoming gradient pops the oldest mask bit.
//   A mask of 1 passes the gradient through unchanged.
//   A mask of 0 zeroes the gradient; in the leaky build it is scaled instead.
//   The output is registered, so latency is exactly one cycle.
//
// Optional feature:
//   `define RELU_BWD_LEAKY_EN : for mask 0, output = gradient >>> LEAK_SHIFT.
//   When undefined, mask 0 gives 0 and LEAK_SHIFT has no effect.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   i_en              block enable (no push/pop when low)
//   i_clr             synchronous flush of FIFO state, errors and output
//   i_fwd_valid/data  forward activation tap (pre-ReLU, signed)
//   i_grad_valid/data upstream gradient (signed)
//   o_valid/o_data    masked gradient; zero whenever o_valid is low
//   o_mask_count      stored mask entries; o_mask_full / o_mask_empty flags
//   o_err_overflow    sticky: forward push dropped while full
//   o_err_underflow   sticky: gradient arrived with an empty FIFO
module relu_bwd_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int MASK_DEPTH = 64,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_en,
  input  logic                          i_clr,
  input  logic                          i_fwd_valid,
  input  logic [DATA_WIDTH-1:0]         i_fwd_data_bus,
  input  logic                          i_grad_valid,
  input  logic [DATA_WIDTH-1:0]         i_grad_data_bus,
  output logic                          o_valid,
  output logic [DATA_WIDTH-1:0]         o_data_bus,
  output logic [$clog2(MASK_DEPTH+1)-1:0] o_mask_count,
  output logic                          o_mask_full,
  output logic                          o_mask_empty,
  output logic                          o_err_overflow,
  output logic                          o_err_underflow
);

  localparam int PW = (MASK_DEPTH > 1) ? $clog2(MASK_DEPTH) : 1;
  localparam int CW = $clog2(MASK_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(MASK_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(MASK_DEPTH - 1);

  // Mask storage: contents are not reset; only pointers and count define validity.
  logic mask_mem_q [MASK_DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_ovf_q, err_ovf_d;
  logic                  err_unf_q, err_unf_d;

  logic                  push;
  logic                  pop;
  logic                  rd_mask;
  logic [DATA_WIDTH-1:0] neg_grad;

  // Only the sign bit of the forward activation matters.
  logic unused_fwd_bits;
  assign unused_fwd_bits = ^i_fwd_data_bus[DATA_WIDTH-2:0];

`ifdef RELU_BWD_LEAKY_EN
  // Arithmetic shift keeps the sign and truncates toward -inf.
  assign neg_grad = $signed(i_grad_data_bus) >>> LEAK_SHIFT;
`else
  assign neg_grad = '0;
  // LEAK_SHIFT only matters in the leaky build; this empty block just references it.
  if (LEAK_SHIFT < 0) begin : g_leak_shift_unused
  end
`endif

  assign rd_mask = mask_mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    full_d    = full_q;
    empty_d   = empty_q;
    err_ovf_d = err_ovf_q;
    err_unf_d = err_unf_q;
    valid_d   = 1'b0;
    data_d    = '0;
    push      = 1'b0;
    pop       = 1'b0;

    if (i_clr) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      full_d    = 1'b0;
      empty_d   = 1'b1;
      err_ovf_d = 1'b0;
      err_unf_d = 1'b0;
    end else if (i_en) begin
      // Pops only see entries already registered: no same-cycle push bypass.
      pop  = i_grad_valid & ~empty_q;
      // A push while full succeeds only if a pop frees a slot in the same cycle.
      push = i_fwd_valid & (~full_q | pop);

      if (i_fwd_valid && full_q && !pop) err_ovf_d = 1'b1;
      if (i_grad_valid && empty_q)       err_unf_d = 1'b1;

      if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
        valid_d  = 1'b1;
        data_d   = rd_mask ? i_grad_data_bus : neg_grad;
      end

      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      full_d  = (count_d == DEPTH_C);
      empty_d = (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mask_mem_q[wr_ptr_q] <= ~i_fwd_data_bus[DATA_WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      valid_q   <= 1'b0;
      data_q    <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  assign o_valid         = valid_q;
  assign o_data_bus      = data_q;
  assign o_mask_count    = count_q;
  assign o_mask_full     = full_q;
  assign o_mask_empty    = empty_q;
  assign o_err_overflow  = err_ovf_q;
  assign o_err_underflow = err_unf_q;

endmodule

// File: tb/tb_relu_bwd_seq.sv
// Directed self-checking bench for relu_bwd_seq (DATA_WIDTH=16, MASK_DEPTH=4).
module tb_relu_bwd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_en = 1'b0;
  logic        i_clr = 1'b0;
  logic        i_fwd_valid = 1'b0;
  logic [15:0] i_fwd_data_bus = '0;
  logic        i_grad_valid = 1'b0;
  logic [15:0] i_grad_data_bus = '0;
  logic        o_valid;
  logic [15:0] o_data_bus;
  logic [2:0]  o_mask_count;
  logic        o_mask_full;
  logic        o_mask_empty;
  logic        o_err_overflow;
  logic        o_err_underflow;

  int errs = 0;
  int checks = 0;

  relu_bwd_seq #(.DATA_WIDTH(16), .MASK_DEPTH(4), .LEAK_SHIFT(3)) dut (
    .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_clr(i_clr),
    .i_fwd_valid(i_fwd_valid), .i_fwd_data_bus(i_fwd_data_bus),
    .i_grad_valid(i_grad_valid), .i_grad_data_bus(i_grad_data_bus),
    .o_valid(o_valid), .o_data_bus(o_data_bus), .o_mask_count(o_mask_count),
    .o_mask_full(o_mask_full), .o_mask_empty(o_mask_empty),
    .o_err_overflow(o_err_overflow), .o_err_underflow(o_err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Apply one cycle of stimulus; returns #1 after the capturing edge.
  task automatic cyc(input logic en, input logic fv, input logic [15:0] fd,
                     input logic gv, input logic [15:0] gd);
    i_en = en; i_clr = 1'b0;
    i_fwd_valid = fv; i_fwd_data_bus = fd;
    i_grad_valid = gv; i_grad_data_bus = gd;
    @(posedge clk); #1;
    i_en = 1'b0; i_fwd_valid = 1'b0; i_grad_valid = 1'b0;
  endtask

  // Clear pulse, with a push and a grad offered that must be ignored.
  task automatic clr_pulse();
    i_clr = 1'b1; i_en = 1'b1;
    i_fwd_valid = 1'b1; i_fwd_data_bus = 16'h0001;
    i_grad_valid = 1'b1; i_grad_data_bus = 16'h0055;
    @(posedge clk); #1;
    i_clr = 1'b0; i_en = 1'b0; i_fwd_valid = 1'b0; i_grad_valid = 1'b0;
  endtask

  function automatic logic [15:0] neg_exp(input logic [15:0] g);
`ifdef RELU_BWD_LEAKY_EN
    return $signed(g) >>> 3;
`else
    return 16'h0000 & g;
`endif
  endfunction

  logic        mq[$];
  logic        m;
  logic [15:0] exp_d;
  logic [15:0] fwd_tab [10] = '{16'h0003, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000,
                                16'hFF00, 16'h0100, 16'h0001, 16'hC000, 16'h0040};
  logic [15:0] grd_tab [10] = '{16'h1111, 16'hFFF0, 16'h2222, 16'h0123, 16'hFF80,
                                16'h0008, 16'h7FFF, 16'h8000, 16'h0404, 16'h0F0F};

  initial begin
    // Reset
    #12;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", 32'(o_data_bus), 32'h0);
    chk("rst_empty", 32'(o_mask_empty), 32'd1);
    chk("rst_full", 32'(o_mask_full), 32'd0);
    chk("rst_count", 32'(o_mask_count), 32'd0);
    chk("rst_ovf", 32'(o_err_overflow), 32'd0);
    chk("rst_unf", 32'(o_err_underflow), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Basic
    cyc(1, 1, 16'h0005, 0, 16'h0);
    cyc(1, 1, 16'hFFFB, 0, 16'h0);
    cyc(1, 1, 16'h0000, 0, 16'h0);
    chk("basic_count3", 32'(o_mask_count), 32'd3);
    cyc(1, 0, 16'h0, 1, 16'h0010);
    chk("basic_v0", 32'(o_valid), 32'd1);
    chk("basic_d0", 32'(o_data_bus), 32'h0010);
    cyc(1, 0, 16'h0, 1, 16'h0020);
    chk("basic_v1", 32'(o_valid), 32'd1);
    chk("basic_d1", 32'(o_data_bus), 32'h0000);
    cyc(1, 0, 16'h0, 1, 16'h0030);
    chk("basic_v2", 32'(o_valid), 32'd1);
    chk("basic_d2", 32'(o_data_bus), 32'h0030);
    chk("basic_empty", 32'(o_mask_empty), 32'd1);
    cyc(1, 0, 16'h0, 0, 16'h0);
    chk("idle_valid", 32'(o_valid), 32'd0);
    chk("idle_data", 32'(o_data_bus), 32'h0);

    // Full / overflow
    for (int i = 1; i <= 4; i++) cyc(1, 1, 16'(i), 0, 16'h0);
    chk("full_flag", 32'(o_mask_full), 32'd1);
    chk("full_count", 32'(o_mask_count), 32'd4);
    chk("full_no_ovf", 32'(o_err_overflow), 32'd0);
    cyc(1, 1, 16'h0005, 0, 16'h0);
    chk("ovf_flag", 32'(o_err_overflow), 32'd1);
    chk("ovf_count", 32'(o_mask_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 16'h0, 1, 16'h0001);
      chk($sformatf("drain_v%0d", i), 32'(o_valid), 32'd1);
      chk($sformatf("drain_d%0d", i), 32'(o_data_bus), 32'h0001);
    end
    chk("drain_empty", 32'(o_mask_empty), 32'd1);
    chk("ovf_sticky", 32'(o_err_overflow), 32'd1);

    // Simultaneous push/pop at full
    clr_pulse();
    chk("clr_ovf", 32'(o_err_overflow), 32'd0);
    chk("clr_count", 32'(o_mask_count), 32'd0);
    chk("clr_valid", 32'(o_valid), 32'd0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 16'h0100, 0, 16'h0);
    cyc(1, 1, 16'h0200, 1, 16'h0042);
    chk("simul_valid", 32'(o_valid), 32'd1);
    chk("simul_data", 32'(o_data_bus), 32'h0042);
    chk("simul_count", 32'(o_mask_count), 32'd4);
    chk("simul_full", 32'(o_mask_full), 32'd1);
    chk("simul_ovf", 32'(o_err_overflow), 32'd0);

    // Enable low: nothing moves, contents retained
    cyc(0, 1, 16'h0001, 1, 16'h0099);
    chk("en0_valid", 32'(o_valid), 32'd0);
    chk("en0_data", 32'(o_data_bus), 32'h0);
    chk("en0_count", 32'(o_mask_count), 32'd4);
    cyc(1, 0, 16'h0, 1, 16'h0077);
    chk("en1_data", 32'(o_data_bus), 32'h0077);

    // Underflow
    clr_pulse();
    cyc(1, 0, 16'h0, 1, 16'h0007);
    chk("unf_valid", 32'(o_valid), 32'd0);
    chk("unf_data", 32'(o_data_bus), 32'h0);
    chk("unf_flag", 32'(o_err_underflow), 32'd1);
    clr_pulse();
    chk("unf_clr", 32'(o_err_underflow), 32'd0);
    chk("unf_clr_empty", 32'(o_mask_empty), 32'd1);

    // Push into empty is not visible to a pop in the same cycle
    cyc(1, 1, 16'h0003, 1, 16'h0004);
    chk("nobypass_valid", 32'(o_valid), 32'd0);
    chk("nobypass_unf", 32'(o_err_underflow), 32'd1);
    chk("nobypass_count", 32'(o_mask_count), 32'd1);
    clr_pulse();

    // Wrap: one negative entry prefilled, then 10 push/pop pairs
    mq.delete();
    cyc(1, 1, 16'h8001, 0, 16'h0);
    mq.push_back(1'b0);
    for (int i = 0; i < 10; i++) begin
      m = mq.pop_front();
      exp_d = m ? grd_tab[i] : neg_exp(grd_tab[i]);
      mq.push_back(~fwd_tab[i][15]);
      cyc(1, 1, fwd_tab[i], 1, grd_tab[i]);
      chk($sformatf("wrap_v%0d", i), 32'(o_valid), 32'd1);
      chk($sformatf("wrap_d%0d", i), 32'(o_data_bus), 32'(exp_d));
    end
    chk("wrap_count", 32'(o_mask_count), 32'd1);

    // Negative-region gradient: leaky gives FFF0>>>3 = FFFE, plain gives 0
    clr_pulse();
    cyc(1, 1, 16'hFFFF, 0, 16'h0);
    cyc(1, 0, 16'h0, 1, 16'hFFF0);
`ifdef RELU_BWD_LEAKY_EN
    chk("leak_data", 32'(o_data_bus), 32'h0000FFFE);
`else
    chk("neg_zero", 32'(o_data_bus), 32'h0);
`endif
    chk("neg_valid", 32'(o_valid), 32'd1);

    // Reset mid-stream
    cyc(1, 1, 16'h0001, 0, 16'h0);
    cyc(1, 1, 16'h0002, 0, 16'h0);
    rst_n = 1'b0; #1;
    chk("midrst_count", 32'(o_mask_count), 32'd0);
    chk("midrst_empty", 32'(o_mask_empty), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    cyc(1, 0, 16'h0, 1, 16'h0011);
    chk("midrst_unf", 32'(o_err_underflow), 32'd1);
    chk("midrst_nov", 32'(o_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
